serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing diff = a − b − borrow_in.
- Built from a single 1-bit full-subtractor cell and a registered borrow, processing one bit per clock, LSB first.
- It is the inverse-direction companion of the team's 1-bit adder cell and targets area-constrained arithmetic datapaths.
- Operands enter and results leave through valid/ready handshakes; one operation is in flight at a time.

---
 rtl/serial_subtractor.sv | 172 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial subtractor computing diff = a - b - borrow_in (mod 2^WIDTH),
// one bit per clock, LSB first, using one full-subtractor cell and a
// registered borrow. One operation is in flight at a time.
//
// Ports:
//   clk        - clock, rising-edge active
//   rst_n      - asynchronous active-low reset
//   in_valid   - operand request
//   in_ready   - high only while idle (operands can be accepted)
//   a, b       - minuend / subtrahend, sampled on input handshake
//   borrow_in  - initial borrow, sampled on input handshake
//   out_valid  - high only while a result is being offered
//   out_ready  - downstream accepts the result
//   diff       - a - b - borrow_in modulo 2^WIDTH
//   borrow_out - unsigned borrow (a < b + borrow_in)
//   overflow   - two's-complement overflow of the signed subtraction
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] diff_sh_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
    logic             a_msb_r;
    logic             b_msb_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_out_r;
    logic             overflow_r;

    logic [1:0]       cell_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH-1:0] diff_next_s;
    logic             last_bit_s;

    // 1-bit full subtractor: returns {borrow_next, difference_bit}
    function automatic logic [1:0] fsub_cell(input logic x, input logic y, input logic bin);
        logic d;
        logic bo;
        d  = x ^ y ^ bin;
        bo = (~x & y) | (~(x ^ y) & bin);
        return {bo, d};
    endfunction

    // Subtractor cell and next-state decode
    always_comb begin
        cell_s      = fsub_cell(a_sh_r[0], b_sh_r[0], br_r);
        // New difference bit enters at the MSB end; the working register
        // holds the completed result after the final RUN cycle.
        shift_s     = {cell_s[0], diff_sh_r};
        diff_next_s = shift_s[WIDTH:1];
        last_bit_s  = (cnt_r == LAST_BIT);
        state_s     = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_bit_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, serial datapath and held result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r       <= '0;
            b_sh_r       <= '0;
            diff_sh_r    <= '0;
            br_r         <= 1'b0;
            cnt_r        <= '0;
            a_msb_r      <= 1'b0;
            b_msb_r      <= 1'b0;
            diff_r       <= '0;
            borrow_out_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_r    <= a;
                        b_sh_r    <= b;
                        diff_sh_r <= '0;
                        br_r      <= borrow_in;
                        cnt_r     <= '0;
                        a_msb_r   <= a[WIDTH-1];
                        b_msb_r   <= b[WIDTH-1];
                    end
                end
                RUN: begin
                    a_sh_r    <= a_sh_r >> 1;
                    b_sh_r    <= b_sh_r >> 1;
                    br_r      <= cell_s[1];
                    diff_sh_r <= diff_next_s;
                    if (last_bit_s) begin
                        // Publish the result only when complete so the held
                        // outputs never show a partially shifted value.
                        diff_r       <= diff_next_s;
                        borrow_out_r <= cell_s[1];
                        overflow_r   <= (a_msb_r ^ b_msb_r) & (diff_next_s[WIDTH-1] ^ a_msb_r);
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    br_r <= br_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign in_ready   = (state_r == IDLE);
    assign out_valid  = (state_r == DONE);
    assign diff       = diff_r;
    assign borrow_out = borrow_out_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Directed, self-checking bench for serial_subtractor (WIDTH = 8).
// Expected results come from a plain arithmetic model and are queued at
// input handshake, then popped and compared when out_valid is observed.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } res_t;

    res_t sb[$];
    int   n_assert;
    int   n_fail;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .borrow_in(borrow_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bin);
        logic [W:0] full;
        res_t r;
        full = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bin};
        r.d  = full[W-1:0];
        r.bo = full[W];
        r.ov = (av[W-1] ^ bv[W-1]) & (r.d[W-1] ^ av[W-1]);
        return r;
    endfunction

    // Wait for out_valid (sampled 1 time unit after each edge); returns cycles waited
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            check("out_valid_timeout", 64'd0, 64'd1);
        end
    endtask

    // Pop the scoreboard and compare the held outputs
    task automatic compare_result(input string tag);
        res_t e;
        check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_diff"}, 64'(diff), 64'(e.d));
            check({tag, "_borrow_out"}, 64'(borrow_out), 64'(e.bo));
            check({tag, "_overflow"}, 64'(overflow), 64'(e.ov));
        end
    endtask

    // Full operation with out_ready already high
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv, input logic bin);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        borrow_in = bin;
        out_ready = 1'b1;
        sb.push_back(model(av, bv, bin));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat);
        check({tag, "_latency"}, 64'(lat), 64'(W));
        compare_result(tag);
        @(posedge clk); #1;
        check({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_diff", 64'(diff), 64'd0);
        check("rst_borrow_out", 64'(borrow_out), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic directed vectors
        run_op("op_05_03", 8'h05, 8'h03, 1'b0);
        run_op("op_03_05", 8'h03, 8'h05, 1'b0);
        run_op("op_80_01", 8'h80, 8'h01, 1'b0);
        run_op("op_00_00_b1", 8'h00, 8'h00, 1'b1);
        run_op("op_7f_ff", 8'h7F, 8'hFF, 1'b0);

        // Backpressure: hold result 0x02 while new operands are offered
        @(negedge clk);
        in_valid  = 1'b1;
        a         = 8'h05;
        b         = 8'h03;
        borrow_in = 1'b0;
        out_ready = 1'b0;
        sb.push_back(model(8'h05, 8'h03, 1'b0));
        @(posedge clk); #1;
        a         = 8'h20;
        b         = 8'h07;
        wait_out(lat);
        check("bp_latency", 64'(lat), 64'(W));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_out_valid", 64'(out_valid), 64'd1);
            check("bp_hold_diff", 64'(diff), 64'h02);
            check("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        compare_result("bp_first");
        @(negedge clk);
        out_ready = 1'b1;
        sb.push_back(model(8'h20, 8'h07, 1'b0));
        @(posedge clk); #1;
        check("bp_idle_in_ready", 64'(in_ready), 64'd1);
        check("bp_idle_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_second_accepted", 64'(in_ready), 64'd0);
        wait_out(lat);
        check("bp_second_latency", 64'(lat), 64'(W));
        compare_result("bp_second");
        @(posedge clk); #1;

        // Reset during RUN at bit 4
        @(negedge clk);
        in_valid  = 1'b1;
        a         = 8'h55;
        b         = 8'h11;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_diff", 64'(diff), 64'h00);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("midrst_no_result", 64'(out_valid), 64'd0);
        end
        run_op("op_10_01", 8'h10, 8'h01, 1'b0);

        check("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
